// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the RV32 5-stage core.
package pipe_pkg;

  localparam int unsigned REG_AW       = 5;
  localparam int unsigned FLUSH_LEFT_W = 3;
  localparam logic [31:0] NOP_INSN     = 32'h00000013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/load_use_cmp.sv
// Combinational load-use hazard compare: ID/EX load targets an IF/ID source register.
module load_use_cmp
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  output logic              load_use_c
);

  // x0 is hard-wired zero, so a load into it never creates a dependency
  assign load_use_c = ex_memread && (ex_rd != REG_AW'(0)) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              mispredict,
  output logic              memory_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              bubble,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [FLUSH_LEFT_W-1:0] FL_RELOAD = FLUSH_LEFT_W'(FLUSH_CYCLES - 1);

  pipe_state_t             state_q, state_d;
  logic [FLUSH_LEFT_W-1:0] flush_left_q, flush_left_d;
  logic                    pending_q, pending_d;
  logic                    ms;
  logic                    lu;

  assign ms           = icache_stall | dcache_stall;
  assign memory_stall = ms;

  load_use_cmp u_load_use_cmp (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .load_use_c (lu)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_left_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      pending_q    <= pending_d;
    end
  end

  // Next-state: STALL with ms low is evaluated exactly like RUN
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    pending_d    = pending_q;
    case (state_q)
      RUN, STALL: begin
        if (ms) begin
          state_d = STALL;
          if (mispredict) pending_d = 1'b1;
        end else if (mispredict || pending_q) begin
          pending_d = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d      = FLUSH;
            flush_left_d = FL_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (ms) begin
          if (mispredict) pending_d = 1'b1;
        end else if (mispredict || pending_q) begin
          pending_d    = 1'b0;
          flush_left_d = FL_RELOAD;
        end else begin
          flush_left_d = flush_left_q - FLUSH_LEFT_W'(1);
          if (flush_left_q == FLUSH_LEFT_W'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output decode; memory stall overrides everything, reset forces the idle pattern
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    flush      = 1'b0;
    if (!rst_n) begin
      pc_write   = 1'b1;
    end else if (ms) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      case (state_q)
        RUN, STALL: begin
          if (mispredict || pending_q) begin
            flush = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
          end
        end
        FLUSH:   flush = 1'b1;
        default: flush = 1'b0;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic             redirect_accept_c;
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  // Every unstalled cycle that sees a mispredict or a held-over flush is one redirect
  assign redirect_accept_c = !ms && (mispredict || pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (ms)                stall_cnt_q  <= stall_cnt_q  + CNT_W'(1);
      if (bubble)            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      if (redirect_accept_c) flush_cnt_q  <= flush_cnt_q  + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
